// File: rtl/inst_mem_sync_if.sv
`timescale 1ns/1ps
// Fetch and program-load signals of the instruction memory, one bundle per core.
// master = fetch stage / boot harness side, slave = memory side.
interface inst_mem_sync_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_pc;
  logic              imem_ready;
  logic              imem_flush;
  logic              imem_stall;
  logic              imem_valid;
  logic [DATA_W-1:0] imem_instruction;
  logic [1:0]        imem_fault;
  logic              load_start;
  logic              load_done;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_busy;
  logic [15:0]       load_count;

  modport master (
    output imem_req, imem_pc, imem_flush, imem_stall,
    output load_start, load_done, load_we, load_addr, load_data,
    input  imem_ready, imem_valid, imem_instruction, imem_fault,
    input  load_busy, load_count
  );

  modport slave (
    input  imem_req, imem_pc, imem_flush, imem_stall,
    input  load_start, load_done, load_we, load_addr, load_data,
    output imem_ready, imem_valid, imem_instruction, imem_fault,
    output load_busy, load_count
  );
endinterface

// File: rtl/inst_mem_sync.sv
`timescale 1ns/1ps
// Clocked instruction memory with run-time program load; fetch data 1 cycle after accept
// (2 cycles for a fetch accepted alongside a flush). Stall holds outputs and drops ready.
module inst_mem_sync #(
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 256,
  parameter int                 ADDR_W   = 32,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic           clk,
  input  logic           reset,
  inst_mem_sync_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic {ST_RUN, ST_LOAD} state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [1:0]        fault_q, fault_d;
  // Fetch accepted together with a flush waits here one cycle before delivery.
  logic              pend_q, pend_d;
  logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
  logic [1:0]        pend_fault_q, pend_fault_d;
  logic [15:0]       load_cnt_q;

  logic              ready;
  logic              accept;
  logic              deliver;
  logic [IDX_W-1:0]  req_idx, rd_idx;
  logic [1:0]        req_fault, rd_fault, ld_fault;
  logic              ld_wr;

  function automatic logic [1:0] addr_fault(input logic [ADDR_W-1:0] a);
    logic [1:0] f;
    f = 2'b00;
    if (a[1:0] != 2'b00)
      f = 2'b01;
    else if (a[ADDR_W-1:IDX_W+2] != '0)
      f = 2'b10;
    return f;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (bus.load_start) state_d = ST_LOAD;
      ST_LOAD: if (!bus.load_start && bus.load_done) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    ready     = (state_q == ST_RUN) && !bus.imem_stall;
    accept    = bus.imem_req && ready;
    req_idx   = bus.imem_pc[IDX_W+1:2];
    req_fault = addr_fault(bus.imem_pc);
    ld_fault  = addr_fault(bus.load_addr);
    ld_wr     = (state_q == ST_LOAD) && bus.load_we && (ld_fault == 2'b00);
  end

  always_comb begin
    vld_d        = vld_q;
    instr_d      = instr_q;
    fault_d      = fault_q;
    pend_d       = pend_q;
    pend_idx_d   = pend_idx_q;
    pend_fault_d = pend_fault_q;
    deliver      = 1'b0;
    rd_idx       = req_idx;
    rd_fault     = req_fault;
    if (state_q == ST_LOAD || bus.load_start) begin
      // Anything in flight when entering LOAD is discarded.
      vld_d   = 1'b0;
      fault_d = 2'b00;
      pend_d  = 1'b0;
    end else if (bus.imem_flush) begin
      vld_d        = 1'b0;
      fault_d      = 2'b00;
      pend_d       = accept;
      pend_idx_d   = req_idx;
      pend_fault_d = req_fault;
    end else if (!bus.imem_stall) begin
      if (pend_q) begin
        deliver      = 1'b1;
        rd_idx       = pend_idx_q;
        rd_fault     = pend_fault_q;
        pend_d       = accept;
        pend_idx_d   = req_idx;
        pend_fault_d = req_fault;
      end else begin
        deliver = accept;
      end
      vld_d   = deliver;
      fault_d = deliver ? rd_fault : 2'b00;
      if (deliver)
        instr_d = (rd_fault != 2'b00) ? NOP_WORD : mem[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q        <= 1'b0;
      instr_q      <= NOP_WORD;
      fault_q      <= 2'b00;
      pend_q       <= 1'b0;
      pend_idx_q   <= '0;
      pend_fault_q <= 2'b00;
    end else begin
      vld_q        <= vld_d;
      instr_q      <= instr_d;
      fault_q      <= fault_d;
      pend_q       <= pend_d;
      pend_idx_q   <= pend_idx_d;
      pend_fault_q <= pend_fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_wr) mem[bus.load_addr[IDX_W+1:2]] <= bus.load_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      load_cnt_q <= '0;
    else if (bus.load_start)
      load_cnt_q <= ld_wr ? 16'd1 : 16'd0;
    else if (ld_wr && load_cnt_q != 16'hFFFF)
      load_cnt_q <= load_cnt_q + 16'd1;
  end

  assign bus.imem_ready       = ready;
  assign bus.imem_valid       = vld_q;
  assign bus.imem_instruction = instr_q;
  assign bus.imem_fault       = fault_q;
  assign bus.load_busy        = (state_q == ST_LOAD);
  assign bus.load_count       = load_cnt_q;
endmodule

// File: tb/tb_inst_mem_sync.sv
`timescale 1ns/1ps
// Directed bench: fetch expectations go into a scoreboard queue, a negedge monitor pops them.
module tb_inst_mem_sync;
  localparam int          DW    = 32;
  localparam int          AW    = 32;
  localparam int          DEPTH = 256;
  localparam logic [31:0] NOP   = 32'h0BAD_F00D;
  localparam logic [31:0] W0    = 32'h2108_000A;
  localparam logic [31:0] W1    = 32'h2009_0005;
  localparam logic [31:0] W8    = 32'h8C0A_0008;
  localparam logic [31:0] W10   = 32'h1111_1111;
  localparam logic [31:0] W14   = 32'h2222_2222;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  fault;
  } exp_t;

  logic clk;
  logic reset;
  logic stall_q;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  inst_mem_sync_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  inst_mem_sync #(
    .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .NOP_WORD(NOP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // A stalled edge leaves the previous output in place, so it is not a new response.
  always @(posedge clk) stall_q <= bus.imem_stall;

  always @(negedge clk) begin
    if (reset && bus.imem_valid && !stall_q) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_fetch: got instr %0h fault %0h with nothing expected",
                 bus.imem_instruction, bus.imem_fault);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("fetch_data", 64'(bus.imem_instruction), 64'(e.data));
        chk("fetch_fault", 64'(bus.imem_fault), 64'(e.fault));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.imem_req   = 1'b0;
    bus.imem_pc    = '0;
    bus.imem_flush = 1'b0;
    bus.imem_stall = 1'b0;
    bus.load_start = 1'b0;
    bus.load_done  = 1'b0;
    bus.load_we    = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] d, input logic [1:0] f);
    exp_t e;
    e.data  = d;
    e.fault = f;
    bus.imem_req = 1'b1;
    bus.imem_pc  = pc;
    sb.push_back(e);
    tick();
  endtask

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    bus.load_we   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    tick();
    bus.load_we   = 1'b0;
  endtask

  task automatic enter_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
  endtask

  task automatic leave_load();
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    idle();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_valid", 64'(bus.imem_valid), 64'd0);
    chk("rst_instr", 64'(bus.imem_instruction), 64'(NOP));
    chk("rst_fault", 64'(bus.imem_fault), 64'd0);
    chk("rst_busy", 64'(bus.load_busy), 64'd0);
    chk("rst_count", 64'(bus.load_count), 64'd0);
    reset = 1'b1;
    tick();
    chk("run_ready", 64'(bus.imem_ready), 64'd1);

    // Program load then two back-to-back fetches.
    enter_load();
    chk("t1_busy", 64'(bus.load_busy), 64'd1);
    chk("t1_ready_in_load", 64'(bus.imem_ready), 64'd0);
    load_word(32'h0, W0);
    load_word(32'h4, W1);
    chk("t1_count", 64'(bus.load_count), 64'd2);
    leave_load();
    chk("t1_busy_off", 64'(bus.load_busy), 64'd0);
    fetch(32'h0, W0, 2'b00);
    chk("t1_valid_p1", 64'(bus.imem_valid), 64'd1);
    fetch(32'h4, W1, 2'b00);
    chk("t1_instr_p2", 64'(bus.imem_instruction), 64'(W1));
    bus.imem_req = 1'b0;
    tick();
    chk("t1_idle_valid", 64'(bus.imem_valid), 64'd0);
    chk("t1_count_kept", 64'(bus.load_count), 64'd2);

    // Faults: misaligned, out of range, and both (misaligned wins).
    fetch(32'h2, NOP, 2'b01);
    fetch(DEPTH * 4, NOP, 2'b10);
    fetch(DEPTH * 4 + 2, NOP, 2'b01);
    bus.imem_req = 1'b0;
    tick();

    // Stall freezes the output; the held request goes in once released.
    fetch(32'h0, W0, 2'b00);
    bus.imem_stall = 1'b1;
    bus.imem_req   = 1'b1;
    bus.imem_pc    = 32'h4;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_ready_stalled", 64'(bus.imem_ready), 64'd0);
      chk("t3_frozen_valid", 64'(bus.imem_valid), 64'd1);
      chk("t3_frozen_instr", 64'(bus.imem_instruction), 64'(W0));
    end
    bus.imem_stall = 1'b0;
    fetch(32'h4, W1, 2'b00);
    chk("t3_released", 64'(bus.imem_instruction), 64'(W1));
    bus.imem_req = 1'b0;
    tick();

    // Flush with a redirect request in the same cycle.
    enter_load();
    load_word(32'h8, W8);
    leave_load();
    fetch(32'h8, W8, 2'b00);
    bus.imem_flush = 1'b1;
    fetch(32'h0, W0, 2'b00);
    bus.imem_flush = 1'b0;
    bus.imem_req   = 1'b0;
    chk("t4_flush_p1_valid", 64'(bus.imem_valid), 64'd0);
    tick();
    chk("t4_flush_p2_valid", 64'(bus.imem_valid), 64'd1);
    chk("t4_flush_p2_instr", 64'(bus.imem_instruction), 64'(W0));
    tick();

    // Reset in the middle of a load keeps the words already written.
    enter_load();
    load_word(32'h10, W10);
    load_word(32'h14, W14);
    chk("t5_count", 64'(bus.load_count), 64'd2);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_instr", 64'(bus.imem_instruction), 64'(NOP));
    chk("t5_rst_busy", 64'(bus.load_busy), 64'd0);
    chk("t5_rst_count", 64'(bus.load_count), 64'd0);
    chk("t5_rst_ready", 64'(bus.imem_ready), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    fetch(32'h10, W10, 2'b00);
    fetch(32'h14, W14, 2'b00);
    bus.imem_req = 1'b0;
    tick();

    // Writes outside LOAD and bad load addresses are ignored.
    bus.load_we   = 1'b1;
    bus.load_addr = 32'h0;
    bus.load_data = 32'hFFFF_FFFF;
    tick();
    bus.load_we = 1'b0;
    chk("t6_run_we_count", 64'(bus.load_count), 64'd0);
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    chk("t6_done_in_run", 64'(bus.load_busy), 64'd0);
    fetch(32'h0, W0, 2'b00);
    bus.imem_req = 1'b0;
    bus.load_start = 1'b1;
    bus.load_done  = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.load_done  = 1'b0;
    chk("t6_start_wins", 64'(bus.load_busy), 64'd1);
    load_word(32'h2, 32'hFFFF_FFFF);
    load_word(DEPTH * 4, 32'hFFFF_FFFF);
    load_word(32'h8000_0000, 32'hFFFF_FFFF);
    chk("t6_bad_addr_count", 64'(bus.load_count), 64'd0);
    leave_load();
    fetch(32'h0, W0, 2'b00);
    fetch(32'h8, W8, 2'b00);
    bus.imem_req = 1'b0;
    repeat (3) tick();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
